// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: walks a PC through a 1-cycle synchronous ROM into a prefetch FIFO.
// Optional IFQ_PERF_EN macro adds a saturating queue-full stall counter port (stall_cnt).
module instr_fetch_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   Run,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_data,
  output logic [DATA_W-1:0]      instr,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] q_count
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, REDIR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, tag;
  logic              inflight;
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_next;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [OW-1:0]     occupancy;
  logic              room, req, push, pop, head_load;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_pc;
  logic [CW-1:0]     count_next;

  assign rom_addr = pc;

  // NOTE: every signal written in an always_comb block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (redirect)  state_next = REDIR;
    else if (Run)  state_next = FETCH;
    else           state_next = IDLE;
  end

  always_comb begin
    // A slot is reserved for the word already in flight, so a push can never overflow.
    occupancy  = OW'(q_count) + OW'(inflight);
    room       = occupancy < OW'(DEPTH);
    req        = (state == FETCH) && Run && !redirect && room;
    push       = inflight && !redirect;
    pop        = instr_valid && instr_ready && !redirect;
    count_next = q_count + CW'(push) - CW'(pop);
    rd_next    = rd_ptr + PW'(1);
    head_load  = 1'b0;
    head_data  = rom_data;
    head_pc    = tag;
    if (pop) begin
      if (q_count > CW'(1)) begin
        head_load = 1'b1;
        head_data = mem_data[rd_next];
        head_pc   = mem_pc[rd_next];
      end else begin
        head_load = push;
      end
    end else begin
      head_load = push && (q_count == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      pc          <= '0;
      tag         <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc          <= redirect_pc;
        inflight    <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        q_count     <= '0;
        instr_valid <= 1'b0;
      end else begin
        inflight    <= req;
        q_count     <= count_next;
        instr_valid <= (count_next != '0);
        if (req) begin
          pc  <= pc + ADDR_W'(1);
          tag <= pc;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_next;
        if (head_load) begin
          instr    <= head_data;
          instr_pc <= head_pc;
        end
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone define which entries are meaningful.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_data[wr_ptr] <= rom_data;
      mem_pc[wr_ptr]   <= tag;
    end
  end

`ifdef IFQ_PERF_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stall_cnt <= '0;
    end else if (redirect) begin
      stall_cnt <= '0;
    end else if ((state == FETCH) && Run && !room && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, corner sequences, then random traffic
// compared each cycle against a queue-based transaction model of the fetch stage.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        Clock, Resetn, Run, instr_ready, redirect, instr_valid;
  logic [5:0]  rom_addr, instr_pc, redirect_pc;
  logic [15:0] rom_data, instr;
  logic [2:0]  q_count;
`ifdef IFQ_PERF_EN
  logic [15:0] stall_cnt;
`endif

  instr_fetch_queue #(.DATA_W(16), .ADDR_W(6), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .q_count(q_count)
`ifdef IFQ_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Program ROM with one cycle of read latency
  logic [15:0] rom [64];
  always @(posedge Clock) rom_data <= rom[rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: the FIFO is a queue of {word, address}; pending is the address whose word lands next cycle
  typedef struct { logic [15:0] data; logic [5:0] pc; } entry_t;
  entry_t      m_q[$];
  int          m_pc, m_pend, m_mode, m_stall;   // m_mode: 0 idle, 1 fetching, 2 redirect hold
  logic [15:0] m_last_instr;
  logic [5:0]  m_last_pc;

  task automatic model_reset();
    m_q.delete();
    m_pc = 0; m_pend = -1; m_mode = 0; m_stall = 0;
    m_last_instr = '0; m_last_pc = '0;
  endtask

  task automatic model_step(input bit run_i, input bit ready_i, input bit redir_i, input logic [5:0] rpc_i);
    bit has_room, can_req;
    has_room = (m_q.size() + ((m_pend >= 0) ? 1 : 0)) < DEPTH;
    can_req  = (m_mode == 1) && run_i && !redir_i && has_room;
    if (redir_i) m_stall = 0;
    else if ((m_mode == 1) && run_i && !has_room && (m_stall < 65535)) m_stall++;
    if (redir_i) begin
      m_q.delete();
      m_pend = -1;
      m_pc   = int'(rpc_i);
      m_mode = 2;
    end else begin
      if (ready_i && (m_q.size() > 0)) void'(m_q.pop_front());
      if (m_pend >= 0) m_q.push_back('{data: rom[m_pend], pc: 6'(m_pend)});
      m_pend = can_req ? m_pc : -1;
      if (can_req) m_pc = (m_pc + 1) % 64;
      m_mode = run_i ? 1 : 0;
    end
    if (m_q.size() > 0) begin
      m_last_instr = m_q[0].data;
      m_last_pc    = m_q[0].pc;
    end
  endtask

  task automatic model_check();
    check("valid", 32'(instr_valid), (m_q.size() > 0) ? 32'd1 : 32'd0);
    check("q_count", 32'(q_count), m_q.size());
    check("rom_addr", 32'(rom_addr), m_pc);
    check("instr", 32'(instr), 32'(m_last_instr));
    check("instr_pc", 32'(instr_pc), 32'(m_last_pc));
`ifdef IFQ_PERF_EN
    check("stall_cnt", 32'(stall_cnt), m_stall);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic tick(input bit run_i, input bit ready_i, input bit redir_i, input logic [5:0] rpc_i);
    Run = run_i; instr_ready = ready_i; redirect = redir_i; redirect_pc = rpc_i;
    model_step(run_i, ready_i, redir_i, rpc_i);
    @(negedge Clock);
    model_check();
  endtask

  task automatic do_reset();
    Resetn = 1'b0; Run = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    model_reset();
    @(negedge Clock);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_count", 32'(q_count), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_pc", 32'(instr_pc), 0);
    Resetn = 1'b1;
  endtask

  typedef struct {
    bit rst; bit run; bit ready;
    bit exp_valid; int exp_pc; int exp_count; int exp_addr;
  } vec_t;
  vec_t vecs[19];

  initial begin
    Resetn = 1'b0; Run = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);

    // Streaming from reset, then back-pressure to full and drain
    vecs[0]  = '{1, 1, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 1, 0, 0, 0, 1};
    vecs[2]  = '{0, 1, 1, 1, 0, 1, 2};
    vecs[3]  = '{0, 1, 1, 1, 1, 1, 3};
    vecs[4]  = '{0, 1, 1, 1, 2, 1, 4};
    vecs[5]  = '{0, 1, 1, 1, 3, 1, 5};
    vecs[6]  = '{1, 1, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 0, 1};
    vecs[8]  = '{0, 1, 0, 1, 0, 1, 2};
    vecs[9]  = '{0, 1, 0, 1, 0, 2, 3};
    vecs[10] = '{0, 1, 0, 1, 0, 3, 4};
    vecs[11] = '{0, 1, 0, 1, 0, 4, 4};
    vecs[12] = '{0, 1, 0, 1, 0, 4, 4};
    vecs[13] = '{0, 1, 0, 1, 0, 4, 4};
    vecs[14] = '{0, 1, 1, 1, 1, 3, 4};
    vecs[15] = '{0, 1, 1, 1, 2, 2, 5};
    vecs[16] = '{0, 1, 1, 1, 3, 2, 6};
    vecs[17] = '{0, 1, 1, 1, 4, 2, 7};
    vecs[18] = '{0, 1, 1, 1, 5, 2, 8};

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].rst) do_reset();
      tick(vecs[i].run, vecs[i].ready, 1'b0, 6'd0);
      check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_count", i), 32'(q_count), vecs[i].exp_count);
      check($sformatf("vec%0d_addr", i), 32'(rom_addr), vecs[i].exp_addr);
      check($sformatf("vec%0d_pc", i), 32'(instr_pc), vecs[i].exp_pc);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_instr", i), 32'(instr), 32'(rom[vecs[i].exp_pc]));
    end

    // Redirect with three queued words and one in flight
    do_reset();
    repeat (5) tick(1'b1, 1'b0, 1'b0, 6'd0);
    check("t3_pre_count", 32'(q_count), 3);
    tick(1'b1, 1'b0, 1'b1, 6'd6);
    check("t3_flush_count", 32'(q_count), 0);
    check("t3_flush_valid", 32'(instr_valid), 0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 6'd0);
    check("t3_first_pc", 32'(instr_pc), 6);
    check("t3_first_instr", 32'(instr), 32'(rom[6]));
    check("t3_first_count", 32'(q_count), 1);

    // Redirect to the top of the address space wraps to 0
    tick(1'b1, 1'b1, 1'b1, 6'd63);
    repeat (3) tick(1'b1, 1'b1, 1'b0, 6'd0);
    check("t4_pc63", 32'(instr_pc), 63);
    tick(1'b1, 1'b1, 1'b0, 6'd0);
    check("t4_pc0", 32'(instr_pc), 0);
    tick(1'b1, 1'b1, 1'b0, 6'd0);
    check("t4_pc1", 32'(instr_pc), 1);

    // Run drops while a request is in flight
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 6'd0);
    tick(1'b1, 1'b0, 1'b0, 6'd0);
    check("t5_addr_req", 32'(rom_addr), 1);
    tick(1'b0, 1'b0, 1'b0, 6'd0);
    check("t5_landed", 32'(q_count), 1);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 6'd0);
    check("t5_addr_hold", 32'(rom_addr), 1);
    check("t5_count_hold", 32'(q_count), 1);
    tick(1'b1, 1'b0, 1'b0, 6'd0);
    tick(1'b1, 1'b0, 1'b0, 6'd0);
    check("t5_resume_addr", 32'(rom_addr), 2);
    tick(1'b1, 1'b0, 1'b0, 6'd0);
    check("t5_resume_count", 32'(q_count), 2);

    // Eight full-queue stall cycles, then asynchronous reset between edges
    do_reset();
    repeat (13) tick(1'b1, 1'b0, 1'b0, 6'd0);
`ifdef IFQ_PERF_EN
    check("t6_stall8", 32'(stall_cnt), 8);
`endif
    #2 Resetn = 1'b0;
    #1;
    check("t6_async_valid", 32'(instr_valid), 0);
    check("t6_async_count", 32'(q_count), 0);
`ifdef IFQ_PERF_EN
    check("t6_async_stall", 32'(stall_cnt), 0);
`endif
    model_reset();
    @(negedge Clock);
    Resetn = 1'b1;

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 9) != 0, ($urandom % 3) != 0,
           $urandom_range(0, 29) == 0, 6'($urandom_range(0, 63)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
